// File: rtl/rvh_noc_pkg.sv
// Shared NoC router types and limits for the output-port credit path.
package rvh_noc_pkg;
    localparam int VC_ID_NUM_MAX        = 6;
    localparam int VC_ID_NUM_MAX_W      = 3;
    localparam int QOS_VC_NUM_PER_INPUT = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } vc_state_e;
endpackage

// File: rtl/output_vc_credit_counter.sv
// One downstream VC: saturating credit counter plus IDLE/ACTIVE wormhole ownership FSM.
// Latency: send/return at edge t reflected in cnt/slot_vld after edge t; slot_vld is purely from registers.
// Backpressure: none; slot_vld drops when credits run out or a packet owns the VC (err port only with RVH_NOC_OUTPORT_CREDIT_ERR_CHK_EN).
module output_vc_credit_counter
    import rvh_noc_pkg::*;
#(
    parameter int VC_DEPTH = 4,
    parameter int VC_CNT_W = $clog2(VC_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                send,
    input  logic                ret,
    input  logic                head,
    input  logic                tail,
    output logic [VC_CNT_W-1:0] cnt,
`ifdef RVH_NOC_OUTPORT_CREDIT_ERR_CHK_EN
    output logic                err,
`endif
    output logic                slot_vld
);

    localparam logic [VC_CNT_W-1:0] CNT_FULL = VC_CNT_W'(VC_DEPTH);
    localparam logic [VC_CNT_W-1:0] CNT_ONE  = VC_CNT_W'(1);

    logic [VC_CNT_W-1:0] cnt_q;
    vc_state_e           state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= CNT_FULL;
        end else if (send && !ret) begin
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
        end else if (ret && !send) begin
            if (cnt_q != CNT_FULL) cnt_q <= cnt_q + CNT_ONE;
        end
    end

    // A head reaching an owned VC is a protocol error; ownership is kept even if it is also a tail.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else if (send) begin
            case (state_q)
                IDLE:    if (head && !tail) state_q <= ACTIVE;
                ACTIVE:  if (tail && !head) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RVH_NOC_OUTPORT_CREDIT_ERR_CHK_EN
    assign err = (send && !ret && (cnt_q == '0))
               | (ret && !send && (cnt_q == CNT_FULL))
               | (send && head && (state_q == ACTIVE));
`endif

    assign cnt      = cnt_q;
    assign slot_vld = (cnt_q != '0) && (state_q == IDLE);

endmodule

// File: rtl/output_port_vc_credit_manager.sv
// Per-output-port downstream VC credit/ownership tracker feeding VC-select candidates (QoS + normal slot per entry).
// Latency: 1 cycle from tx/credit event to vc_select_vld_o / vc_credit_cnt_o; outputs depend on registers only.
// Backpressure: none; a VC with no credit or an in-flight packet is withdrawn. Error checking gated by RVH_NOC_OUTPORT_CREDIT_ERR_CHK_EN.
module output_port_vc_credit_manager
    import rvh_noc_pkg::*;
#(
    parameter int OUTPUT_VC_NUM = 4,
    parameter int VC_DEPTH      = 4,
    parameter int VC_CNT_W      = $clog2(VC_DEPTH + 1),
    parameter int DST_VC_NUM    = OUTPUT_VC_NUM + 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             tx_flit_vld_i,
    input  logic [2:0]                       tx_flit_vc_id_i,
    input  logic                             tx_flit_head_i,
    input  logic                             tx_flit_tail_i,
    input  logic                             rx_lcrd_vld_i,
    input  logic [2:0]                       rx_lcrd_id_i,
    output logic [OUTPUT_VC_NUM*2-1:0]       vc_select_vld_o,
    output logic [OUTPUT_VC_NUM*6-1:0]       vc_select_vc_id_o,
    output logic [DST_VC_NUM*VC_CNT_W-1:0]   vc_credit_cnt_o,
    output logic                             credit_err_o
);

    localparam logic [VC_ID_NUM_MAX_W-1:0] QOS_VC_ID = VC_ID_NUM_MAX_W'(OUTPUT_VC_NUM);

    logic [DST_VC_NUM-1:0] send_v;
    logic [DST_VC_NUM-1:0] ret_v;
    logic [DST_VC_NUM-1:0] slot_vld;
`ifdef RVH_NOC_OUTPORT_CREDIT_ERR_CHK_EN
    logic [DST_VC_NUM-1:0] vc_err;
`endif

    for (genvar v = 0; v < DST_VC_NUM; v++) begin : g_vc
        assign send_v[v] = tx_flit_vld_i && (tx_flit_vc_id_i == VC_ID_NUM_MAX_W'(v));
        assign ret_v[v]  = rx_lcrd_vld_i && (rx_lcrd_id_i == VC_ID_NUM_MAX_W'(v));

        output_vc_credit_counter #(
            .VC_DEPTH (VC_DEPTH),
            .VC_CNT_W (VC_CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rstn     (rstn),
            .send     (send_v[v]),
            .ret      (ret_v[v]),
            .head     (tx_flit_head_i),
            .tail     (tx_flit_tail_i),
            .cnt      (vc_credit_cnt_o[v*VC_CNT_W +: VC_CNT_W]),
`ifdef RVH_NOC_OUTPORT_CREDIT_ERR_CHK_EN
            .err      (vc_err[v]),
`endif
            .slot_vld (slot_vld[v])
        );
    end

    // Every entry offers the single QoS VC in slot 0 and its own normal VC in slot 1.
    for (genvar j = 0; j < OUTPUT_VC_NUM; j++) begin : g_sel
        assign vc_select_vld_o[2*j]         = slot_vld[OUTPUT_VC_NUM];
        assign vc_select_vld_o[2*j+1]       = slot_vld[j];
        assign vc_select_vc_id_o[6*j +: 3]  = QOS_VC_ID;
        assign vc_select_vc_id_o[6*j+3 +: 3] = VC_ID_NUM_MAX_W'(j);
    end

`ifdef RVH_NOC_OUTPORT_CREDIT_ERR_CHK_EN
    logic tx_oor;
    logic lcrd_oor;
    logic credit_err_q;

    assign tx_oor   = tx_flit_vld_i && (tx_flit_vc_id_i >= VC_ID_NUM_MAX_W'(DST_VC_NUM));
    assign lcrd_oor = rx_lcrd_vld_i && (rx_lcrd_id_i >= VC_ID_NUM_MAX_W'(DST_VC_NUM));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) credit_err_q <= 1'b0;
        else       credit_err_q <= credit_err_q | (|vc_err) | tx_oor | lcrd_oor;
    end

    assign credit_err_o = credit_err_q;
`else
    assign credit_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_output_port_vc_credit_manager.sv
// Scoreboarded bench for output_port_vc_credit_manager: directed scenarios followed by random traffic.
module tb_output_port_vc_credit_manager;

    localparam int NVC = 4;
    localparam int DEP = 4;
    localparam int CW  = 3;
    localparam int DV  = NVC + 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              tx_flit_vld_i = 1'b0;
    logic [2:0]        tx_flit_vc_id_i = '0;
    logic              tx_flit_head_i = 1'b0;
    logic              tx_flit_tail_i = 1'b0;
    logic              rx_lcrd_vld_i = 1'b0;
    logic [2:0]        rx_lcrd_id_i = '0;
    logic [NVC*2-1:0]  vc_select_vld_o;
    logic [NVC*6-1:0]  vc_select_vc_id_o;
    logic [DV*CW-1:0]  vc_credit_cnt_o;
    logic              credit_err_o;

    output_port_vc_credit_manager #(
        .OUTPUT_VC_NUM (NVC),
        .VC_DEPTH      (DEP)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .tx_flit_vld_i     (tx_flit_vld_i),
        .tx_flit_vc_id_i   (tx_flit_vc_id_i),
        .tx_flit_head_i    (tx_flit_head_i),
        .tx_flit_tail_i    (tx_flit_tail_i),
        .rx_lcrd_vld_i     (rx_lcrd_vld_i),
        .rx_lcrd_id_i      (rx_lcrd_id_i),
        .vc_select_vld_o   (vc_select_vld_o),
        .vc_select_vc_id_o (vc_select_vc_id_o),
        .vc_credit_cnt_o   (vc_credit_cnt_o),
        .credit_err_o      (credit_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NVC*2-1:0] vld;
        logic [DV*CW-1:0] cnt;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt[DV];
    bit   m_act[DV];
    bit   m_err;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int v = 0; v < DV; v++) begin
            m_cnt[v] = DEP;
            m_act[v] = 1'b0;
        end
        m_err = 1'b0;
    endfunction

    function automatic exp_t model_snap();
        exp_t e;
        bit   qos_ok;
        qos_ok = (m_cnt[NVC] != 0) && !m_act[NVC];
        for (int j = 0; j < NVC; j++) begin
            e.vld[2*j]   = qos_ok;
            e.vld[2*j+1] = (m_cnt[j] != 0) && !m_act[j];
        end
        for (int v = 0; v < DV; v++) e.cnt[v*CW +: CW] = 3'(m_cnt[v]);
        e.err = m_err;
        return e;
    endfunction

    function automatic void model_step(input bit tv, input int tid, input bit h, input bit t,
                                       input bit lv, input int lid);
        bit ev = 1'b0;
        if (tv) begin
            if (tid >= DV) ev = 1'b1;
            else begin
                if (!(lv && lid == tid)) begin
                    if (m_cnt[tid] == 0) ev = 1'b1;
                    else m_cnt[tid]--;
                end
                if (h && m_act[tid]) ev = 1'b1;
                if (!m_act[tid] && h && !t)     m_act[tid] = 1'b1;
                else if (m_act[tid] && t && !h) m_act[tid] = 1'b0;
            end
        end
        if (lv) begin
            if (lid >= DV) ev = 1'b1;
            else if (!(tv && tid == lid)) begin
                if (m_cnt[lid] == DEP) ev = 1'b1;
                else m_cnt[lid]++;
            end
        end
`ifdef RVH_NOC_OUTPORT_CREDIT_ERR_CHK_EN
        m_err = m_err | ev;
`else
        ev = 1'b0;
        m_err = m_err | ev;
`endif
    endfunction

    // Drive one cycle of stimulus, queue the predicted result, compare it after the edge.
    task automatic cycle(input string tag, input bit tv, input int tid, input bit h, input bit t,
                         input bit lv, input int lid);
        exp_t e;
        tx_flit_vld_i   = tv;
        tx_flit_vc_id_i = 3'(tid);
        tx_flit_head_i  = h;
        tx_flit_tail_i  = t;
        rx_lcrd_vld_i   = lv;
        rx_lcrd_id_i    = 3'(lid);
        model_step(tv, tid, h, t, lv, lid);
        exp_q.push_back(model_snap());
        @(posedge clk);
        #1;
        tx_flit_vld_i = 1'b0;
        rx_lcrd_vld_i = 1'b0;
        e = exp_q.pop_front();
        check_eq({tag, "_vld"}, 32'(vc_select_vld_o), 32'(e.vld));
        check_eq({tag, "_cnt"}, 32'(vc_credit_cnt_o), 32'(e.cnt));
        check_eq({tag, "_err"}, 32'(credit_err_o), 32'(e.err));
    endtask

    task automatic check_reset_state(input string tag);
        logic [NVC*6-1:0] ids;
        logic [DV*CW-1:0] full;
        for (int j = 0; j < NVC; j++) begin
            ids[6*j +: 3]   = 3'(NVC);
            ids[6*j+3 +: 3] = 3'(j);
        end
        for (int v = 0; v < DV; v++) full[v*CW +: CW] = 3'(DEP);
        check_eq({tag, "_vld"}, 32'(vc_select_vld_o), 32'h0000_00FF);
        check_eq({tag, "_cnt"}, 32'(vc_credit_cnt_o), 32'(full));
        check_eq({tag, "_err"}, 32'(credit_err_o), 32'd0);
        check_eq({tag, "_ids"}, 32'(vc_select_vc_id_o), 32'(ids));
        check_eq({tag, "_e2s1"}, 32'(vc_select_vc_id_o[17:15]), 32'd2);
        check_eq({tag, "_e2s0"}, 32'(vc_select_vc_id_o[14:12]), 32'd4);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst_hold");
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("rst_rel");

        // Credit exhaustion on VC1 with single-flit packets
        for (int i = 0; i < 4; i++) cycle("t2_send", 1, 1, 1, 1, 0, 0);
        check_eq("t2_cnt1_zero", 32'(vc_credit_cnt_o[5:3]), 32'd0);
        check_eq("t2_bit3_low", 32'(vc_select_vld_o[3]), 32'd0);
        cycle("t2_ret", 0, 0, 0, 0, 1, 1);
        check_eq("t2_bit3_high", 32'(vc_select_vld_o[3]), 32'd1);

        // Wormhole ownership on VC2
        cycle("t3_head", 1, 2, 1, 0, 0, 0);
        check_eq("t3_bit5_owned", 32'(vc_select_vld_o[5]), 32'd0);
        check_eq("t3_cnt2", 32'(vc_credit_cnt_o[8:6]), 32'd3);
        cycle("t3_body0", 1, 2, 0, 0, 0, 0);
        cycle("t3_body1", 1, 2, 0, 0, 0, 0);
        cycle("t3_tail", 1, 2, 0, 1, 0, 0);
        check_eq("t3_cnt2_zero", 32'(vc_credit_cnt_o[8:6]), 32'd0);
        cycle("t3_ret", 0, 0, 0, 0, 1, 2);
        check_eq("t3_bit5_back", 32'(vc_select_vld_o[5]), 32'd1);

        // Simultaneous send/return: same VC and different VCs
        cycle("t4_s0a", 1, 0, 1, 1, 0, 0);
        cycle("t4_s0b", 1, 0, 1, 1, 0, 0);
        cycle("t4_same", 1, 0, 1, 1, 1, 0);
        check_eq("t4_cnt0_held", 32'(vc_credit_cnt_o[2:0]), 32'd2);
        cycle("t4_diff", 1, 3, 1, 1, 1, 1);

        // Overflow and out-of-range id
        cycle("t5_ret3", 0, 0, 0, 0, 1, 3);
        cycle("t5_ovf", 0, 0, 0, 0, 1, 3);
        check_eq("t5_cnt3_sat", 32'(vc_credit_cnt_o[11:9]), 32'd4);
        cycle("t5_oor", 1, 7, 1, 1, 0, 0);

        // Asynchronous reset mid-packet on the QoS VC
        cycle("t6_head", 1, 4, 1, 0, 0, 0);
        cycle("t6_body0", 1, 4, 0, 0, 0, 0);
        cycle("t6_body1", 1, 4, 0, 0, 0, 0);
        check_eq("t6_cnt4", 32'(vc_credit_cnt_o[14:12]), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check_reset_state("t6_async");
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;

        // Random traffic, including protocol violations
        for (int i = 0; i < 400; i++) begin
            bit tv, lv, h, t;
            int tid, lid;
            tv  = ($urandom_range(0, 3) != 0);
            lv  = ($urandom_range(0, 2) != 0);
            h   = ($urandom_range(0, 1) != 0);
            t   = ($urandom_range(0, 1) != 0);
            tid = ($urandom_range(0, 15) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            lid = ($urandom_range(0, 15) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            cycle("rnd", tv, tid, h, t, lv, lid);
        end

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
